// File: rtl/axi_slave_if.sv
// AXI-Lite style write (AW/W/B) and read (AR/R) channel bundles shared by
// the slave and whatever master drives it.

interface axi_write_interface;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );
endinterface

interface axi_read_interface;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_slave.sv
// AXI-Lite slave bridging to a simple request/done peripheral port.
// Write and read paths are independent FSMs with per-access timeouts.

module axi_slave #(
    parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
    parameter int unsigned ADDRESS_RANGE  = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    axi_write_interface.slave write_channel,
    axi_read_interface.slave  read_channel,
    output logic [31:0] write_address_o,
    output logic [31:0] write_data_o,
    output logic [3:0]  write_strobe_o,
    output logic        write_request_o,
    input  logic        write_done_i,
    input  logic        write_error_i,
    output logic [31:0] read_address_o,
    output logic        read_request_o,
    input  logic [31:0] read_data_i,
    input  logic        read_done_i,
    input  logic        read_error_i
);

    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlverr = 2'b10;
    localparam logic [1:0]  RespDecerr = 2'b11;
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [32:0] WindowEnd   = {1'b0, BASE_ADDRESS} + 33'(ADDRESS_RANGE);

    typedef enum logic [1:0] {W_IDLE, W_ACCESS, W_RESPONSE} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESPONSE} r_state_e;

    // 33-bit compare so a window touching 2^32 cannot wrap.
    function automatic logic in_window(input logic [31:0] addr);
        return ({1'b0, addr} >= {1'b0, BASE_ADDRESS}) && ({1'b0, addr} < WindowEnd);
    endfunction

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    logic        active_q;
    logic        aw_latched_q, w_latched_q, aw_in_window_q;
    logic [7:0]  w_timer_q, r_timer_q;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] write_address_q, write_data_q, read_address_q;
    logic [3:0]  write_strobe_q;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        aw_have, w_have, aw_ok;

    assign aw_hs   = write_channel.AWVALID && write_channel.AWREADY;
    assign w_hs    = write_channel.WVALID && write_channel.WREADY;
    assign b_hs    = write_channel.BVALID && write_channel.BREADY;
    assign ar_hs   = read_channel.ARVALID && read_channel.ARREADY;
    assign r_hs    = read_channel.RVALID && read_channel.RREADY;
    assign aw_have = aw_latched_q || aw_hs;
    assign w_have  = w_latched_q || w_hs;
    assign aw_ok   = aw_latched_q ? aw_in_window_q : in_window(write_channel.AWADDR);

    // State registers
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            active_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            active_q  <= 1'b1;
        end
    end

    // Write next-state
    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_have && w_have) begin
                    if (aw_ok) begin
                        w_state_d = W_ACCESS;
                    end else begin
                        w_state_d = W_RESPONSE;
                        bresp_d   = RespDecerr;
                    end
                end
            end
            W_ACCESS: begin
                if (write_done_i) begin
                    w_state_d = W_RESPONSE;
                    bresp_d   = write_error_i ? RespSlverr : RespOkay;
                end else if (w_timer_q == TimeoutLast) begin
                    w_state_d = W_RESPONSE;
                    bresp_d   = RespSlverr;
                end
            end
            W_RESPONSE: begin
                if (b_hs) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read next-state
    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    if (in_window(read_channel.ARADDR)) begin
                        r_state_d = R_ACCESS;
                    end else begin
                        r_state_d = R_RESPONSE;
                        rresp_d   = RespDecerr;
                        rdata_d   = 32'h0;
                    end
                end
            end
            R_ACCESS: begin
                if (read_done_i) begin
                    r_state_d = R_RESPONSE;
                    rresp_d   = read_error_i ? RespSlverr : RespOkay;
                    rdata_d   = read_data_i;
                end else if (r_timer_q == TimeoutLast) begin
                    r_state_d = R_RESPONSE;
                    rresp_d   = RespSlverr;
                    rdata_d   = 32'h0;
                end
            end
            R_RESPONSE: begin
                if (r_hs) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Datapath: latched transaction, timers and responses
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_latched_q    <= 1'b0;
            w_latched_q     <= 1'b0;
            aw_in_window_q  <= 1'b0;
            write_address_q <= 32'h0;
            write_data_q    <= 32'h0;
            write_strobe_q  <= 4'h0;
            read_address_q  <= 32'h0;
            w_timer_q       <= 8'h0;
            r_timer_q       <= 8'h0;
            bresp_q         <= RespOkay;
            rresp_q         <= RespOkay;
            rdata_q         <= 32'h0;
        end else begin
            if (aw_hs) begin
                aw_latched_q    <= 1'b1;
                aw_in_window_q  <= in_window(write_channel.AWADDR);
                write_address_q <= write_channel.AWADDR - BASE_ADDRESS;
            end
            if (w_hs) begin
                w_latched_q    <= 1'b1;
                write_data_q   <= write_channel.WDATA;
                write_strobe_q <= write_channel.WSTRB;
            end
            if (b_hs) begin
                aw_latched_q <= 1'b0;
                w_latched_q  <= 1'b0;
            end
            if (ar_hs) read_address_q <= read_channel.ARADDR - BASE_ADDRESS;
            // Timers sit at zero outside ACCESS, so entry always starts from zero.
            w_timer_q <= (w_state_q == W_ACCESS) ? w_timer_q + 8'd1 : 8'h0;
            r_timer_q <= (r_state_q == R_ACCESS) ? r_timer_q + 8'd1 : 8'h0;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Outputs
    always_comb begin
        write_channel.AWREADY = active_q && (w_state_q == W_IDLE) && !aw_latched_q;
        write_channel.WREADY  = active_q && (w_state_q == W_IDLE) && !w_latched_q;
        write_channel.BVALID  = (w_state_q == W_RESPONSE);
        write_channel.BRESP   = bresp_q;
        write_request_o       = (w_state_q == W_ACCESS);
        write_address_o       = write_address_q;
        write_data_o          = write_data_q;
        write_strobe_o        = write_strobe_q;
        read_channel.ARREADY  = active_q && (r_state_q == R_IDLE);
        read_channel.RVALID   = (r_state_q == R_RESPONSE);
        read_channel.RRESP    = rresp_q;
        read_channel.RDATA    = rdata_q;
        read_request_o        = (r_state_q == R_ACCESS);
        read_address_o        = read_address_q;
    end

endmodule

// File: tb/tb_axi_slave.sv
// Directed bench for axi_slave: one instance at base 0 with an 8-cycle
// timeout, a second at base 0x1000 / 256 bytes for offset and window edges.

module tb_axi_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] wa, wd, ra, ra2, wa2, wd2;
    logic [3:0]  ws, ws2;
    logic        wreq, wdone, werr, rreq, rdone, rerr;
    logic        wreq2, rreq2, rdone2;
    logic [31:0] rdata_in, rdata_in2;
    int          checks = 0;
    int          errors = 0;

    axi_write_interface wr_if ();
    axi_read_interface  rd_if ();
    axi_write_interface wr2_if ();
    axi_read_interface  rd2_if ();

    axi_slave #(
        .BASE_ADDRESS  (32'h0000_0000),
        .ADDRESS_RANGE (4096),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK           (aclk),
        .ARESETN        (aresetn),
        .write_channel  (wr_if),
        .read_channel   (rd_if),
        .write_address_o(wa),
        .write_data_o   (wd),
        .write_strobe_o (ws),
        .write_request_o(wreq),
        .write_done_i   (wdone),
        .write_error_i  (werr),
        .read_address_o (ra),
        .read_request_o (rreq),
        .read_data_i    (rdata_in),
        .read_done_i    (rdone),
        .read_error_i   (rerr)
    );

    axi_slave #(
        .BASE_ADDRESS  (32'h0000_1000),
        .ADDRESS_RANGE (256),
        .TIMEOUT_CYCLES(255)
    ) dut2 (
        .ACLK           (aclk),
        .ARESETN        (aresetn),
        .write_channel  (wr2_if),
        .read_channel   (rd2_if),
        .write_address_o(wa2),
        .write_data_o   (wd2),
        .write_strobe_o (ws2),
        .write_request_o(wreq2),
        .write_done_i   (1'b0),
        .write_error_i  (1'b0),
        .read_address_o (ra2),
        .read_request_o (rreq2),
        .read_data_i    (rdata_in2),
        .read_done_i    (rdone2),
        .read_error_i   (1'b0)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic rd2_decerr(input logic [31:0] addr);
        rd2_if.ARADDR = addr;
        rd2_if.ARVALID = 1'b1;
        tick();
        rd2_if.ARVALID = 1'b0;
        check("dec2_rvalid", 32'(rd2_if.RVALID), 32'h1);
        check("dec2_rresp", 32'(rd2_if.RRESP), 32'h3);
        check("dec2_rreq", 32'(rreq2), 32'h0);
        rd2_if.RREADY = 1'b1;
        tick();
        rd2_if.RREADY = 1'b0;
    endtask

    initial begin
        wr_if.AWADDR = '0; wr_if.AWVALID = 0; wr_if.WDATA = '0; wr_if.WSTRB = '0;
        wr_if.WVALID = 0; wr_if.BREADY = 0;
        rd_if.ARADDR = '0; rd_if.ARVALID = 0; rd_if.RREADY = 0;
        wr2_if.AWADDR = '0; wr2_if.AWVALID = 0; wr2_if.WDATA = '0; wr2_if.WSTRB = '0;
        wr2_if.WVALID = 0; wr2_if.BREADY = 0;
        rd2_if.ARADDR = '0; rd2_if.ARVALID = 0; rd2_if.RREADY = 0;
        wdone = 0; werr = 0; rdone = 0; rerr = 0; rdata_in = '0;
        rdone2 = 0; rdata_in2 = '0;

        // Reset state
        tick(); tick();
        check("rst_awready", 32'(wr_if.AWREADY), 32'h0);
        check("rst_wready", 32'(wr_if.WREADY), 32'h0);
        check("rst_arready", 32'(rd_if.ARREADY), 32'h0);
        check("rst_bvalid", 32'(wr_if.BVALID), 32'h0);
        check("rst_rvalid", 32'(rd_if.RVALID), 32'h0);
        check("rst_wreq", 32'(wreq), 32'h0);
        check("rst_rdata", rd_if.RDATA, 32'h0);
        aresetn = 1'b1;
        tick();
        check("rel_awready", 32'(wr_if.AWREADY), 32'h1);
        check("rel_wready", 32'(wr_if.WREADY), 32'h1);
        check("rel_arready", 32'(rd_if.ARREADY), 32'h1);

        // AW and W in the same cycle, done three cycles later
        wr_if.AWADDR = 32'h10; wr_if.AWVALID = 1;
        wr_if.WDATA = 32'hDEADBEEF; wr_if.WSTRB = 4'hF; wr_if.WVALID = 1;
        tick();
        wr_if.AWVALID = 0; wr_if.WVALID = 0;
        check("w1_req", 32'(wreq), 32'h1);
        check("w1_addr", wa, 32'h10);
        check("w1_data", wd, 32'hDEADBEEF);
        check("w1_strb", 32'(ws), 32'hF);
        check("w1_awready", 32'(wr_if.AWREADY), 32'h0);
        tick(); tick();
        check("w1_req_hold", 32'(wreq), 32'h1);
        wdone = 1;
        tick();
        wdone = 0;
        check("w1_bvalid", 32'(wr_if.BVALID), 32'h1);
        check("w1_bresp", 32'(wr_if.BRESP), 32'h0);
        check("w1_req_off", 32'(wreq), 32'h0);
        wr_if.BREADY = 1;
        tick();
        wr_if.BREADY = 0;
        check("w1_bdone", 32'(wr_if.BVALID), 32'h0);
        check("w1_awready_back", 32'(wr_if.AWREADY), 32'h1);

        // Stray done in idle is ignored
        wdone = 1;
        tick();
        wdone = 0;
        check("stray_req", 32'(wreq), 32'h0);
        check("stray_bvalid", 32'(wr_if.BVALID), 32'h0);

        // W two cycles ahead of AW, then SLVERR from the peripheral
        wr_if.WDATA = 32'hDEADBEEF; wr_if.WSTRB = 4'h3; wr_if.WVALID = 1;
        tick();
        wr_if.WVALID = 0; wr_if.WDATA = 32'h0;
        check("w2_wready", 32'(wr_if.WREADY), 32'h0);
        check("w2_awready", 32'(wr_if.AWREADY), 32'h1);
        check("w2_noreq", 32'(wreq), 32'h0);
        tick();
        check("w2_noreq2", 32'(wreq), 32'h0);
        wr_if.AWADDR = 32'h24; wr_if.AWVALID = 1;
        tick();
        wr_if.AWVALID = 0;
        check("w2_req", 32'(wreq), 32'h1);
        check("w2_addr", wa, 32'h24);
        check("w2_data", wd, 32'hDEADBEEF);
        check("w2_strb", 32'(ws), 32'h3);
        wdone = 1; werr = 1;
        tick();
        wdone = 0; werr = 0;
        tick();
        check("w2_bvalid", 32'(wr_if.BVALID), 32'h1);
        check("w2_bresp", 32'(wr_if.BRESP), 32'h2);
        wr_if.BREADY = 1;
        tick();
        wr_if.BREADY = 0;

        // Out-of-window read
        rd_if.ARADDR = 32'h2000; rd_if.ARVALID = 1;
        tick();
        rd_if.ARVALID = 0;
        check("r1_rvalid", 32'(rd_if.RVALID), 32'h1);
        check("r1_rresp", 32'(rd_if.RRESP), 32'h3);
        check("r1_rdata", rd_if.RDATA, 32'h0);
        check("r1_rreq", 32'(rreq), 32'h0);
        rd_if.RREADY = 1;
        tick();
        rd_if.RREADY = 0;

        // Read error, response held while RREADY stays low
        rd_if.ARADDR = 32'h40; rd_if.ARVALID = 1;
        tick();
        rd_if.ARVALID = 0;
        check("r2_rreq", 32'(rreq), 32'h1);
        check("r2_raddr", ra, 32'h40);
        check("r2_arready", 32'(rd_if.ARREADY), 32'h0);
        rdone = 1; rerr = 1; rdata_in = 32'h1234;
        tick();
        rdone = 0; rerr = 0; rdata_in = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("r2_rvalid", 32'(rd_if.RVALID), 32'h1);
            check("r2_rresp", 32'(rd_if.RRESP), 32'h2);
            check("r2_rdata", rd_if.RDATA, 32'h1234);
            tick();
        end
        rd_if.RREADY = 1;
        tick();
        rd_if.RREADY = 0;
        check("r2_rdone", 32'(rd_if.RVALID), 32'h0);
        check("r2_arready_back", 32'(rd_if.ARREADY), 32'h1);

        // Write timeout after 8 access cycles with an independent read
        wr_if.AWADDR = 32'h80; wr_if.AWVALID = 1;
        wr_if.WDATA = 32'h55; wr_if.WSTRB = 4'hF; wr_if.WVALID = 1;
        rd_if.ARADDR = 32'h84; rd_if.ARVALID = 1;
        tick();
        wr_if.AWVALID = 0; wr_if.WVALID = 0; rd_if.ARVALID = 0;
        check("t_wreq", 32'(wreq), 32'h1);
        check("t_rreq", 32'(rreq), 32'h1);
        tick();
        rdone = 1; rdata_in = 32'hCAFEF00D;
        tick();
        rdone = 0;
        check("t_rvalid", 32'(rd_if.RVALID), 32'h1);
        check("t_rresp", 32'(rd_if.RRESP), 32'h0);
        check("t_rdata", rd_if.RDATA, 32'hCAFEF00D);
        check("t_wreq_busy", 32'(wreq), 32'h1);
        rd_if.RREADY = 1;
        tick();
        rd_if.RREADY = 0;
        check("t_rdone", 32'(rd_if.RVALID), 32'h0);
        tick(); tick(); tick(); tick();
        check("t_wreq_last", 32'(wreq), 32'h1);
        check("t_bvalid_early", 32'(wr_if.BVALID), 32'h0);
        tick();
        check("t_bvalid", 32'(wr_if.BVALID), 32'h1);
        check("t_bresp", 32'(wr_if.BRESP), 32'h2);
        check("t_wreq_off", 32'(wreq), 32'h0);
        wr_if.BREADY = 1;
        tick();
        wr_if.BREADY = 0;

        // Reset during W_ACCESS
        wr_if.AWADDR = 32'h8; wr_if.AWVALID = 1;
        wr_if.WDATA = 32'h77; wr_if.WVALID = 1;
        tick();
        wr_if.AWVALID = 0; wr_if.WVALID = 0;
        check("ra_wreq", 32'(wreq), 32'h1);
        aresetn = 0;
        tick();
        check("ra_wreq_rst", 32'(wreq), 32'h0);
        check("ra_awready_rst", 32'(wr_if.AWREADY), 32'h0);
        check("ra_arready_rst", 32'(rd_if.ARREADY), 32'h0);
        check("ra_waddr_rst", wa, 32'h0);
        check("ra_wdata_rst", wd, 32'h0);
        aresetn = 1;
        wdone = 1;
        tick();
        wdone = 0;
        check("ra_awready", 32'(wr_if.AWREADY), 32'h1);
        check("ra_wready", 32'(wr_if.WREADY), 32'h1);
        check("ra_arready", 32'(rd_if.ARREADY), 32'h1);
        tick(); tick();
        check("ra_no_bvalid", 32'(wr_if.BVALID), 32'h0);

        // Non-zero base: offset at the top byte and both window edges
        rd2_if.ARADDR = 32'h10FF; rd2_if.ARVALID = 1;
        tick();
        rd2_if.ARVALID = 0;
        check("b2_rreq", 32'(rreq2), 32'h1);
        check("b2_raddr", ra2, 32'hFF);
        rdone2 = 1; rdata_in2 = 32'hA5A5;
        tick();
        rdone2 = 0;
        check("b2_rresp", 32'(rd2_if.RRESP), 32'h0);
        check("b2_rdata", rd2_if.RDATA, 32'hA5A5);
        rd2_if.RREADY = 1;
        tick();
        rd2_if.RREADY = 0;
        rd2_decerr(32'h1100);
        rd2_decerr(32'h0FFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
